// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_defs_pkg
//  Description : Shared definitions for the multi-cycle MIPS datapath:
//                architectural register indices, datapath widths and the
//                register-index type.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;   // $0, hard-wired zero
    localparam reg_idx_t REG_SP   = 5'd29;  // $sp
    localparam reg_idx_t REG_RA   = 5'd31;  // $ra, jal link target

endpackage : cpu_defs_pkg
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_read_port
//  Description : One combinational read port of the register file. Selects
//                the addressed register, forces $0 to zero and, when
//                REGFILE_BYPASS_EN is defined, forwards the in-flight write
//                data for a same-cycle read of the register being written.
//  Ports       : i_regs      - full register array contents
//                i_rd_idx    - read index
//                o_rd_data   - read data
//                i_wr_en     - qualified write enable  (bypass build only)
//                i_wr_idx    - write index             (bypass build only)
//                i_wr_data   - write data              (bypass build only)
//  Config      : REGFILE_BYPASS_EN - enables same-cycle write-through
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
    import cpu_defs_pkg::*;
#(
    parameter int DATA_W = cpu_defs_pkg::DATA_W,
    parameter int ADDR_W = cpu_defs_pkg::ADDR_W
) (
    input  logic [DATA_W-1:0] i_regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data
`ifdef REGFILE_BYPASS_EN
    ,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_idx,
    input  logic [DATA_W-1:0] i_wr_data
`endif
);

    always_comb begin
        o_rd_data = i_regs[i_rd_idx];
        // $0 is forced here rather than relying on the storage, so neither a
        // stray write nor the bypass path can ever make it non-zero.
        if (i_rd_idx == ADDR_W'(REG_ZERO)) begin
            o_rd_data = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (i_wr_en && (i_wr_idx == i_rd_idx)) begin
            o_rd_data = i_wr_data;
        end
`endif
    end

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/reg_file_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_2r1w
//  Description : 32 x 32-bit MIPS general-purpose register file with two
//                combinational read ports and one synchronous write port.
//                $0 always reads zero; $29 resets to SP_INIT, all others to 0.
//  Ports       : CLK        - clock, writes on rising edge
//                Reset      - asynchronous active-low clear of the array
//                RegWre     - write enable
//                ReadReg1   - read port 1 index (rs)
//                ReadReg2   - read port 2 index (rt)
//                WriteReg   - write index (from RegDst select)
//                WriteData  - write-back data
//                ReadData1  - contents of ReadReg1
//                ReadData2  - contents of ReadReg2
//  Config      : REGFILE_BYPASS_EN - same-cycle write-through on reads
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_2r1w
    import cpu_defs_pkg::*;
#(
    parameter int                 DATA_W  = cpu_defs_pkg::DATA_W,
    parameter int                 ADDR_W  = cpu_defs_pkg::ADDR_W,
    parameter logic [DATA_W-1:0]  SP_INIT = '0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              RegWre,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam int NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];

    // Reset takes priority over any coincident clock edge, so a write that
    // lands while Reset is low is discarded.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
            end
        end else if (RegWre && (WriteReg != ADDR_W'(REG_ZERO))) begin
            r_regs[WriteReg] <= WriteData;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding is only legal when the write will actually commit.
    logic w_wr_commit;
    assign w_wr_commit = RegWre & Reset;
`endif

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_port1 (
        .i_regs    (r_regs),
        .i_rd_idx  (ReadReg1),
        .o_rd_data (ReadData1)
`ifdef REGFILE_BYPASS_EN
        ,
        .i_wr_en   (w_wr_commit),
        .i_wr_idx  (WriteReg),
        .i_wr_data (WriteData)
`endif
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_port2 (
        .i_regs    (r_regs),
        .i_rd_idx  (ReadReg2),
        .o_rd_data (ReadData2)
`ifdef REGFILE_BYPASS_EN
        ,
        .i_wr_en   (w_wr_commit),
        .i_wr_idx  (WriteReg),
        .i_wr_data (WriteData)
`endif
    );

    // An enabled write with an unknown destination would corrupt an
    // unpredictable register.
    a_wr_idx_known : assert property (
        @(posedge CLK) disable iff (!Reset) RegWre |-> !$isunknown(WriteReg)
    );

endmodule : reg_file_2r1w
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_2r1w
//  Description : Self-checking bench for reg_file_2r1w. An array model of the
//                32 architectural registers predicts both read ports; a
//                negedge compare process checks them every cycle, and
//                directed scenarios add literal expectations.
//  Config      : REGFILE_BYPASS_EN - selects same-cycle read expectations
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_2r1w;
    import cpu_defs_pkg::*;

    localparam logic [31:0] SP_VAL = 32'h0000_3FFC;

    logic        CLK;
    logic        Reset;
    logic        RegWre;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int n_vec;
    int n_bad;

    logic [31:0] model [32];

    reg_file_2r1w #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .SP_INIT (SP_VAL)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .RegWre    (RegWre),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model[29] = SP_VAL;
    endtask

    initial model_clear();

    always @(posedge CLK or negedge Reset) begin
        if (!Reset) model_clear();
        else if (RegWre && WriteReg != 5'd0) model[WriteReg] = WriteData;
    end

    function automatic logic [31:0] expect_rd(logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (RegWre && Reset && WriteReg == idx) return WriteData;
`endif
        return model[idx];
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Continuous compare away from the active edge.
    always @(negedge CLK) begin
        check("cyc_rd1", ReadData1, expect_rd(ReadReg1));
        check("cyc_rd2", ReadData2, expect_rd(ReadReg2));
    end

    // Advance to just after the next rising edge.
    task automatic edge_step();
        @(posedge CLK);
        #2;
    endtask

    task automatic wr(logic [4:0] idx, logic [31:0] data);
        RegWre    = 1'b1;
        WriteReg  = idx;
        WriteData = data;
        edge_step();
        RegWre    = 1'b0;
    endtask

    // Directed write/read vectors: index, data; readback checked by model.
    logic [4:0]  vec_idx  [6] = '{5'd1, 5'd2, 5'd17, 5'd29, 5'd30, 5'd1};
    logic [31:0] vec_data [6] = '{32'h0000_0001, 32'h8000_0000, 32'hCAFE_F00D,
                                  32'h7FFF_FFF0, 32'h1357_9BDF, 32'h2222_2222};

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        Reset     = 1'b1;
        RegWre    = 1'b0;
        ReadReg1  = 5'd0;
        ReadReg2  = 5'd29;
        WriteReg  = 5'd0;
        WriteData = 32'h0;

        // 1. asynchronous reset, checked before the first clock edge
        #1 Reset = 1'b0;
        #1;
        check("rst_r0",  ReadData1, 32'h0);
        check("rst_sp",  ReadData2, 32'h0000_3FFC);
        ReadReg1 = 5'd31; ReadReg2 = 5'd8;
        #1;
        check("rst_r31", ReadData1, 32'h0);
        check("rst_r8",  ReadData2, 32'h0);
        edge_step();
        Reset = 1'b1;
        edge_step();

        // 2. basic write, both ports on the same register
        ReadReg1 = 5'd8; ReadReg2 = 5'd8;
        wr(5'd8, 32'hDEAD_BEEF);
        check("wr8_p1", ReadData1, 32'hDEAD_BEEF);
        check("wr8_p2", ReadData2, 32'hDEAD_BEEF);

        // 3. $0 is never written
        ReadReg1 = 5'd0; ReadReg2 = 5'd0;
        wr(5'd0, 32'hFFFF_FFFF);
        check("r0_p1", ReadData1, 32'h0);
        check("r0_p2", ReadData2, 32'h0);

        // 4. RegWre=0 leaves the array alone
        ReadReg2  = 5'd9;
        WriteReg  = 5'd9;
        WriteData = 32'h0000_1234;
        edge_step();
        check("nowre_r9", ReadData2, 32'h0);

        // directed vectors, compare process checks readback each cycle
        for (int i = 0; i < 6; i++) begin
            ReadReg1 = vec_idx[i];
            ReadReg2 = vec_idx[(i + 5) % 6];
            wr(vec_idx[i], vec_data[i]);
        end
        ReadReg1 = 5'd1; ReadReg2 = 5'd29;
        #1;
        check("vec_r1",  ReadData1, 32'h2222_2222);
        check("vec_r29", ReadData2, 32'h7FFF_FFF0);
        ReadReg1 = 5'd17; ReadReg2 = 5'd8;
        #1;
        check("vec_r17", ReadData1, 32'hCAFE_F00D);
        check("vec_r8",  ReadData2, 32'hDEAD_BEEF);

        // 6. same-cycle read of the register being written
        ReadReg1  = 5'd5;
        RegWre    = 1'b1;
        WriteReg  = 5'd5;
        WriteData = 32'hA5A5_A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("same_cyc_r5", ReadData1, 32'hA5A5_A5A5);
`else
        check("same_cyc_r5", ReadData1, 32'h0);
`endif
        edge_step();
        RegWre = 1'b0;
        check("after_r5", ReadData1, 32'hA5A5_A5A5);

        // 5. jal link write, then reset mid-cycle with a write pending
        ReadReg2 = 5'd31;
        wr(5'd31, 32'h0040_0010);
        check("jal_r31", ReadData2, 32'h0040_0010);
        RegWre    = 1'b1;
        WriteReg  = 5'd31;
        WriteData = 32'h1234_5678;
        ReadReg1  = 5'd29;
        #2 Reset = 1'b0;
        #1;
        check("midrst_r31", ReadData2, 32'h0);
        check("midrst_sp",  ReadData1, 32'h0000_3FFC);
        edge_step();
        check("rstedge_r31", ReadData2, 32'h0);
        RegWre = 1'b0;
        Reset  = 1'b1;
        ReadReg1 = 5'd8;
        edge_step();
        check("postrst_r8",  ReadData1, 32'h0);
        check("postrst_r31", ReadData2, 32'h0);
        edge_step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_reg_file_2r1w
`default_nettype wire
